// File: rtl/multi_tone_pwm_if.sv
// Configuration port of multi_tone_pwm: valid-ready write of one channel's
// phase increment and waveform mode.
interface multi_tone_pwm_if #(
  parameter int PHASE_WIDTH = 24
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [2:0]             cfg_channel;
  logic [PHASE_WIDTH-1:0] cfg_increment;
  logic [1:0]             cfg_mode;

  modport master (
    output cfg_valid, cfg_channel, cfg_increment, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_channel, cfg_increment, cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/multi_tone_pwm.sv
// Multi-channel tone generator: phase accumulators -> shaper -> saturating mix
// -> first-order sigma-delta PWM (PWM only when MULTI_TONE_PWM_EN is defined).
module multi_tone_pwm #(
  parameter int BIT_WIDTH   = 16,
  parameter int CHANNELS    = 2,
  parameter int PHASE_WIDTH = 24
) (
  input  logic                        clk_audio,
  input  logic                        RESETn,
  multi_tone_pwm_if.slave             cfg,
  output logic signed [BIT_WIDTH-1:0] sample_word,
  output logic                        sample_valid,
  output logic                        clip,
  output logic                        pwm_out
);

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SILENT = 2'd3
  } mode_e;

  localparam int SUM_W = BIT_WIDTH + $clog2(CHANNELS);
  localparam int TOP_W = SUM_W - BIT_WIDTH + 1;
  localparam logic [BIT_WIDTH-1:0] MSB = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic [PHASE_WIDTH-1:0]      phase  [CHANNELS];
  logic [PHASE_WIDTH-1:0]      incr   [CHANNELS];
  mode_e                       mode   [CHANNELS];
  logic signed [BIT_WIDTH-1:0] shaped [CHANNELS];

  logic                        ready_q;
  logic                        transfer;
  logic                        valid_d;
  logic signed [SUM_W-1:0]     mix_sum;
  logic [TOP_W-1:0]            mix_top;
  logic                        mix_sat;
  logic signed [BIT_WIDTH-1:0] mix_word;

  assign transfer      = cfg.cfg_valid && ready_q;
  assign cfg.cfg_ready = ready_q;

  function automatic logic signed [BIT_WIDTH-1:0] shape(input logic [BIT_WIDTH-1:0] u,
                                                        input mode_e m);
    logic [BIT_WIDTH-2:0] t;
    t = u[BIT_WIDTH-1] ? ~u[BIT_WIDTH-2:0] : u[BIT_WIDTH-2:0];
    case (m)
      MODE_SAW:    shape = u ^ MSB;
      MODE_SQUARE: shape = u[BIT_WIDTH-1] ? MSB : ~MSB;
      MODE_TRI:    shape = {t, 1'b0} ^ MSB;
      default:     shape = '0;
    endcase
  endfunction

  // A written channel restarts from phase 0; out-of-range channels still handshake.
  always_ff @(posedge clk_audio or negedge RESETn) begin
    if (!RESETn) begin
      ready_q <= 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        phase[i] <= '0;
        incr[i]  <= '0;
        mode[i]  <= MODE_SILENT;
      end
    end else begin
      ready_q <= !transfer;
      for (int i = 0; i < CHANNELS; i++) begin
        if (transfer && (int'(cfg.cfg_channel) == i)) begin
          incr[i]  <= cfg.cfg_increment;
          mode[i]  <= mode_e'(cfg.cfg_mode);
          phase[i] <= '0;
        end else begin
          phase[i] <= phase[i] + incr[i];
        end
      end
    end
  end

  always_ff @(posedge clk_audio or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < CHANNELS; i++) shaped[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        shaped[i] <= shape(phase[i][PHASE_WIDTH-1 -: BIT_WIDTH], mode[i]);
    end
  end

  // Out of range whenever the guard bits above the sample width disagree.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < CHANNELS; i++) mix_sum = mix_sum + SUM_W'(shaped[i]);
    mix_top  = mix_sum[SUM_W-1 -: TOP_W];
    mix_sat  = !((&mix_top) || !(|mix_top));
    mix_word = mix_sat ? (mix_sum[SUM_W-1] ? MSB : ~MSB) : mix_sum[BIT_WIDTH-1:0];
  end

  always_ff @(posedge clk_audio or negedge RESETn) begin
    if (!RESETn) begin
      sample_word  <= '0;
      clip         <= 1'b0;
      valid_d      <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_word  <= mix_word;
      clip         <= mix_sat;
      valid_d      <= 1'b1;
      sample_valid <= valid_d;
    end
  end

`ifdef MULTI_TONE_PWM_EN
  logic [BIT_WIDTH:0] acc;

  // Offset-binary input; the carry out of the low W bits is the bitstream.
  always_ff @(posedge clk_audio or negedge RESETn) begin
    if (!RESETn) acc <= '0;
    else         acc <= {1'b0, acc[BIT_WIDTH-1:0]} + {1'b0, sample_word ^ MSB};
  end

  assign pwm_out = acc[BIT_WIDTH];
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_multi_tone_pwm.sv
// Directed scoreboard bench for multi_tone_pwm (BIT_WIDTH 16, CHANNELS 2,
// PHASE_WIDTH 24); checks PWM density or the tied-off pin per MULTI_TONE_PWM_EN.
module tb_multi_tone_pwm;

  typedef struct {
    logic [15:0] word;
    logic        clip;
    string       tag;
  } exp_t;

  logic        clk_audio;
  logic        RESETn;
  logic [15:0] sample_word;
  logic        sample_valid;
  logic        clip;
  logic        pwm_out;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  multi_tone_pwm_if #(.PHASE_WIDTH(24)) cfg_bus ();

  multi_tone_pwm #(
    .BIT_WIDTH  (16),
    .CHANNELS   (2),
    .PHASE_WIDTH(24)
  ) dut (
    .clk_audio   (clk_audio),
    .RESETn      (RESETn),
    .cfg         (cfg_bus.slave),
    .sample_word (sample_word),
    .sample_valid(sample_valid),
    .clip        (clip),
    .pwm_out     (pwm_out)
  );

  initial clk_audio = 1'b0;
  always #5 clk_audio = ~clk_audio;

  task automatic tick();
    @(negedge clk_audio);
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] ch,
                               input logic [23:0] inc, input logic [1:0] mode);
    cfg_bus.cfg_valid     = valid;
    cfg_bus.cfg_channel   = ch;
    cfg_bus.cfg_increment = inc;
    cfg_bus.cfg_mode      = mode;
  endtask

  task automatic pushExp(input logic [15:0] w, input logic c, input string tag);
    exp_t e;
    e.word = w;
    e.clip = c;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      checkVal(e.tag, 32'(sample_word), 32'(e.word));
      checkVal({e.tag, "_clip"}, 32'(clip), 32'(e.clip));
    end
  endtask

  // Drive one request for a single cycle; returns at the negedge after the accept edge.
  task automatic doConfig(input logic [2:0] ch, input logic [23:0] inc, input logic [1:0] mode);
    applyStimulus(1'b1, ch, inc, mode);
    tick();
    applyStimulus(1'b0, 3'd0, 24'd0, 2'd0);
  endtask

  initial begin
    logic [23:0] ph;
    logic [15:0] w;
    int          ones;
    int          nonzero;

    RESETn = 1'b0;
    applyStimulus(1'b0, 3'd0, 24'd0, 2'd0);
    tick();
    checkVal("rst_word",  32'(sample_word),       32'd0);
    checkVal("rst_valid", 32'(sample_valid),      32'd0);
    checkVal("rst_clip",  32'(clip),              32'd0);
    checkVal("rst_pwm",   32'(pwm_out),           32'd0);
    checkVal("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    tick();
    RESETn = 1'b1;
    tick();
    checkVal("valid_edge1", 32'(sample_valid), 32'd0);
    tick();
    checkVal("valid_edge2", 32'(sample_valid), 32'd1);

    $display("[TB] saw ramp, increment 256");
    pushExp(16'h0000, 1'b0, "saw_lat0");
    pushExp(16'h0000, 1'b0, "saw_lat1");
    for (int n = 0; n < 20; n++) begin
      w = 16'h8000 + 16'(n);
      pushExp(w, 1'b0, "saw_ramp");
    end
    doConfig(3'd0, 24'd256, 2'd0);
    checkVal("ready_after_accept", 32'(cfg_bus.cfg_ready), 32'd0);
    checkOutput();
    tick();
    checkVal("ready_recovered", 32'(cfg_bus.cfg_ready), 32'd1);
    checkOutput();
    for (int n = 0; n < 20; n++) begin
      tick();
      checkOutput();
    end

    $display("[TB] saw wrap, increment 0x555555");
    doConfig(3'd0, 24'h555555, 2'd0);
    tick();
    ph = 24'd0;
    for (int n = 0; n < 9; n++) begin
      pushExp(ph[23:8] ^ 16'h8000, 1'b0, "saw_wrap");
      ph = ph + 24'h555555;
    end
    for (int n = 0; n < 9; n++) begin
      tick();
      checkOutput();
    end

    $display("[TB] handshake with valid held, both channels square");
    pushExp(16'h7FFF, 1'b0, "sq_one");
    pushExp(16'h7FFF, 1'b0, "sq_one");
    for (int n = 0; n < 4; n++) pushExp(16'h7FFF, 1'b1, "sq_clip");
    applyStimulus(1'b1, 3'd0, 24'd0, 2'd1);
    checkVal("hs_ready0", 32'(cfg_bus.cfg_ready), 32'd1);
    tick();
    checkVal("hs_ready1", 32'(cfg_bus.cfg_ready), 32'd0);
    applyStimulus(1'b1, 3'd1, 24'd0, 2'd0);
    tick();
    checkVal("hs_ready2", 32'(cfg_bus.cfg_ready), 32'd1);
    applyStimulus(1'b1, 3'd1, 24'd0, 2'd1);
    tick();
    checkVal("hs_ready3", 32'(cfg_bus.cfg_ready), 32'd0);
    applyStimulus(1'b1, 3'd0, 24'd0, 2'd0);
    checkOutput();
    tick();
    applyStimulus(1'b0, 3'd0, 24'd0, 2'd0);
    checkOutput();
    for (int n = 0; n < 4; n++) begin
      tick();
      checkOutput();
    end

    $display("[TB] ch1 silent removes clip");
    pushExp(16'h7FFF, 1'b1, "sil_lat0");
    pushExp(16'h7FFF, 1'b1, "sil_lat1");
    pushExp(16'h7FFF, 1'b0, "sil_noclip");
    pushExp(16'h7FFF, 1'b0, "sil_noclip");
    doConfig(3'd1, 24'd0, 2'd3);
    checkOutput();
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput();
    end

    $display("[TB] out-of-range channel 7");
    for (int n = 0; n < 6; n++) pushExp(16'h7FFF, 1'b0, "ch7_nochange");
    doConfig(3'd7, 24'd256, 2'd0);
    checkVal("ch7_accepted", 32'(cfg_bus.cfg_ready), 32'd0);
    checkOutput();
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput();
    end

    $display("[TB] triangle quarter steps, increment 0x400000");
    pushExp(16'h7FFF, 1'b0, "tri_lat0");
    pushExp(16'h7FFF, 1'b0, "tri_lat1");
    for (int r = 0; r < 2; r++) begin
      pushExp(16'h8000, 1'b0, "tri_min");
      pushExp(16'h0000, 1'b0, "tri_q1");
      pushExp(16'h7FFE, 1'b0, "tri_peak");
      pushExp(16'hFFFE, 1'b0, "tri_q3");
    end
    doConfig(3'd0, 24'h400000, 2'd2);
    checkOutput();
    for (int n = 0; n < 9; n++) begin
      tick();
      checkOutput();
    end

    $display("[TB] triangle ramp, increment 256");
    doConfig(3'd0, 24'd256, 2'd2);
    tick();
    for (int n = 0; n < 10; n++) begin
      w = 16'h8000 + 16'(2 * n);
      pushExp(w, 1'b0, "tri_rise");
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checkOutput();
    end

    $display("[TB] reset mid-operation with in-flight request");
    applyStimulus(1'b1, 3'd0, 24'd256, 2'd1);
    #2;
    RESETn = 1'b0;
    #1;
    checkVal("midrst_word",  32'(sample_word),       32'd0);
    checkVal("midrst_valid", 32'(sample_valid),      32'd0);
    checkVal("midrst_clip",  32'(clip),              32'd0);
    checkVal("midrst_pwm",   32'(pwm_out),           32'd0);
    checkVal("midrst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    tick();
    tick();
    applyStimulus(1'b0, 3'd0, 24'd0, 2'd0);
    RESETn = 1'b1;
    exp_q.delete();
    tick();
    checkVal("midrst_valid_edge1", 32'(sample_valid), 32'd0);
    tick();
    checkVal("midrst_valid_edge2", 32'(sample_valid), 32'd1);
    checkVal("midrst_word_after",  32'(sample_word),  32'd0);

    $display("[TB] PWM density over 65536 cycles at sample_word 0");
    ones    = 0;
    nonzero = 0;
    for (int n = 0; n < 65536; n++) begin
      tick();
      if (pwm_out === 1'b1) ones++;
      if (sample_word !== 16'h0000) nonzero++;
    end
    checkVal("discarded_cfg_word", 32'(nonzero), 32'd0);
`ifdef MULTI_TONE_PWM_EN
    checkVal("pwm_density", 32'(ones), 32'd32768);
`else
    checkVal("pwm_tied_low", 32'(ones), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
